// File: rtl/sd_init_if.sv
// sd_init_if: SPI bus between the SD init sequencer (master) and the card (slave).
interface sd_init_if;
  logic SD_MOSI;
  logic SD_CSn;
  logic SD_MISO;

  modport master (output SD_MOSI, output SD_CSn, input SD_MISO);
  modport slave  (input SD_MOSI, input SD_CSn, output SD_MISO);
endinterface

// File: rtl/sd_init.sv
// sd_init: SPI-mode SD card initialization sequencer.
// Power-up clocks, CMD0, CMD8, CMD55+ACMD41 polling, then init_o is raised.
// Optional macro SD_INIT_CMD58_EN: after ACMD41 succeeds, read the OCR with
// CMD58 and report its CCS bit on ccs (otherwise ccs is tied to 0).
// State and bus outputs change on the falling SD_CK edge; MISO is sampled on
// the rising edge, giving SPI mode 0.
module sd_init #(
  parameter int POWERUP_CLKS = 80,
  parameter int GAP_CLKS     = 8,
  parameter int RESP_TIMEOUT = 64,
  parameter int MAX_RETRY    = 1000
) (
  input  logic      SD_CK,
  input  logic      rst,
  input  logic      start,
  sd_init_if.master sd,
  output logic      init_o,
  output logic      init_err,
  output logic      ccs
);
  localparam int CMAX_A = (POWERUP_CLKS > RESP_TIMEOUT) ? POWERUP_CLKS : RESP_TIMEOUT;
  localparam int CMAX   = (CMAX_A > GAP_CLKS) ? CMAX_A : GAP_CLKS;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int RW     = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CLKS - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CLKS - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(RESP_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE, S_POWERUP, S_GAP, S_SEND_CMD, S_WAIT_RESP,
    S_RECV_RESP, S_CHECK, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    C_CMD0, C_CMD8, C_CMD55, C_ACMD41
`ifdef SD_INIT_CMD58_EN
    , C_CMD58
`endif
  } cmd_t;

  state_t        state_reg;
  cmd_t          cmd_reg;
  logic [CW-1:0] cnt_reg;
  logic [5:0]    bit_cnt_reg;
  logic [47:0]   tx_reg;
  logic [39:0]   shift_reg;
  logic [RW-1:0] retry_reg;
  logic          csn_reg;
  logic          mosi_reg;
  logic          init_reg;
  logic          err_reg;
  logic          miso_s;

  logic [47:0]   frame;
  logic          long_resp;
  logic [5:0]    resp_last;
  logic [7:0]    r1;
  logic          unused_resp;

  // Command frame for the command about to be sent
  always_comb begin
    frame = 48'hFFFF_FFFF_FFFF;
    case (cmd_reg)
      C_CMD0:   frame = 48'h40_0000_0000_95;
      C_CMD8:   frame = 48'h48_0000_01AA_87;
      C_CMD55:  frame = 48'h77_0000_0000_65;
      C_ACMD41: frame = 48'h69_4000_0000_77;
`ifdef SD_INIT_CMD58_EN
      C_CMD58:  frame = 48'h7A_0000_0000_FD;
`endif
      default:  frame = 48'hFFFF_FFFF_FFFF;
    endcase
  end

  // R7 (CMD8) and R3 (CMD58) are 40 bits with R1 in the top byte; R1 alone is 8 bits
`ifdef SD_INIT_CMD58_EN
  assign long_resp = (cmd_reg == C_CMD8) || (cmd_reg == C_CMD58);
`else
  assign long_resp = (cmd_reg == C_CMD8);
`endif
  assign resp_last   = long_resp ? 6'd39 : 6'd7;
  assign r1          = long_resp ? shift_reg[39:32] : shift_reg[7:0];
  assign unused_resp = ^shift_reg[31:12];

  // Sample card data on the rising edge; the FSM consumes it on the next falling edge
  always_ff @(posedge SD_CK) begin
    miso_s <= sd.SD_MISO;
  end

  // Main sequencer: all state and bus outputs registered on the falling edge
  always_ff @(negedge SD_CK) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cmd_reg     <= C_CMD0;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      tx_reg      <= '0;
      shift_reg   <= '0;
      retry_reg   <= '0;
      csn_reg     <= 1'b1;
      mosi_reg    <= 1'b1;
      init_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          csn_reg  <= 1'b1;
          mosi_reg <= 1'b1;
          if (start) begin
            state_reg <= S_POWERUP;
            cnt_reg   <= '0;
          end
        end
        S_POWERUP: begin
          csn_reg  <= 1'b1;
          mosi_reg <= 1'b1;
          if (cnt_reg == PWR_LAST) begin
            state_reg <= S_GAP;
            cmd_reg   <= C_CMD0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_GAP: begin
          csn_reg  <= 1'b1;
          mosi_reg <= 1'b1;
          if (cnt_reg == GAP_LAST) begin
            state_reg   <= S_SEND_CMD;
            tx_reg      <= frame;
            bit_cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_SEND_CMD: begin
          csn_reg     <= 1'b0;
          mosi_reg    <= tx_reg[47];
          tx_reg      <= {tx_reg[46:0], 1'b1};
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 6'd47) begin
            state_reg <= S_WAIT_RESP;
            cnt_reg   <= '0;
          end
        end
        S_WAIT_RESP: begin
          csn_reg  <= 1'b0;
          mosi_reg <= 1'b1;
          if (!miso_s) begin
            // The start bit is the response MSB; it is the zero left in the cleared register
            state_reg   <= S_RECV_RESP;
            shift_reg   <= '0;
            bit_cnt_reg <= 6'd1;
          end else if (cnt_reg == TMO_LAST) begin
            state_reg <= S_ERROR;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_RECV_RESP: begin
          csn_reg     <= 1'b0;
          mosi_reg    <= 1'b1;
          shift_reg   <= {shift_reg[38:0], miso_s};
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == resp_last) begin
            state_reg <= S_CHECK;
          end
        end
        S_CHECK: begin
          csn_reg   <= 1'b1;
          mosi_reg  <= 1'b1;
          cnt_reg   <= '0;
          state_reg <= S_ERROR;
          case (cmd_reg)
            C_CMD0: begin
              if (r1 == 8'h01) begin
                state_reg <= S_GAP;
                cmd_reg   <= C_CMD8;
              end
            end
            C_CMD8: begin
              if (r1 == 8'h01 && shift_reg[11:0] == 12'h1AA) begin
                state_reg <= S_GAP;
                cmd_reg   <= C_CMD55;
              end
            end
            C_CMD55: begin
              if (r1 == 8'h01 || r1 == 8'h00) begin
                state_reg <= S_GAP;
                cmd_reg   <= C_ACMD41;
              end
            end
            C_ACMD41: begin
              if (r1 == 8'h00) begin
`ifdef SD_INIT_CMD58_EN
                state_reg <= S_GAP;
                cmd_reg   <= C_CMD58;
`else
                state_reg <= S_DONE;
`endif
              end else if (r1 == 8'h01) begin
                retry_reg <= retry_reg + 1'b1;
                if (retry_reg + 1'b1 != RETRY_MAX) begin
                  state_reg <= S_GAP;
                  cmd_reg   <= C_CMD55;
                end
              end
            end
`ifdef SD_INIT_CMD58_EN
            C_CMD58: begin
              if (r1 == 8'h00) begin
                state_reg <= S_DONE;
              end
            end
`endif
            default: state_reg <= S_ERROR;
          endcase
        end
        S_DONE: begin
          csn_reg  <= 1'b1;
          mosi_reg <= 1'b1;
          init_reg <= 1'b1;
        end
        S_ERROR: begin
          csn_reg  <= 1'b1;
          mosi_reg <= 1'b1;
          err_reg  <= 1'b1;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef SD_INIT_CMD58_EN
  logic ccs_reg;

  // Capture CCS (OCR bit 30) from a good CMD58 response
  always_ff @(negedge SD_CK) begin
    if (rst) begin
      ccs_reg <= 1'b0;
    end else if (state_reg == S_CHECK && cmd_reg == C_CMD58 && r1 == 8'h00) begin
      ccs_reg <= shift_reg[30];
    end
  end

  assign ccs = ccs_reg;
`else
  assign ccs = 1'b0;
`endif

  assign sd.SD_CSn  = csn_reg;
  assign sd.SD_MOSI = mosi_reg;
  assign init_o     = init_reg;
  assign init_err   = err_reg;
endmodule

// File: tb/tb_sd_init.sv
// tb_sd_init: directed bench for sd_init with a behavioural SPI SD card model.
module tb_sd_init;
  localparam int POWERUP = 80;
  localparam int GAP     = 8;
  localparam int TMO     = 64;
  localparam int RETRY   = 4;
`ifdef SD_INIT_CMD58_EN
  localparam logic EXP_CCS   = 1'b1;
  localparam int   EXP_N58   = 1;
`else
  localparam logic EXP_CCS   = 1'b0;
  localparam int   EXP_N58   = 0;
`endif

  logic SD_CK = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic init_o, init_err, ccs;

  sd_init_if bus();

  sd_init #(
    .POWERUP_CLKS(POWERUP),
    .GAP_CLKS    (GAP),
    .RESP_TIMEOUT(TMO),
    .MAX_RETRY   (RETRY)
  ) dut (
    .SD_CK   (SD_CK),
    .rst     (rst),
    .start   (start),
    .sd      (bus),
    .init_o  (init_o),
    .init_err(init_err),
    .ccs     (ccs)
  );

  always #5 SD_CK = ~SD_CK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Card model configuration and observations
  logic [7:0]  cmd8_r1     = 8'h01;
  int          acmd41_busy = 2;
  bit          silent_cmd0 = 1'b0;
  int          n_cmd0, n_cmd8, n_cmd55, n_acmd41, n_cmd58, n_frames;
  int          rx_cnt, neg_cnt, cmd0_end;
  logic [47:0] rx_sr, first_frame, f_cmd8, f_cmd55, f_acmd41, f_cmd58;
  bit          resp_q[$];

  task automatic handle_frame(input logic [47:0] f);
    logic [39:0] r;
    int          len;
    r   = '0;
    len = 8;
    n_frames++;
    case (f[47:40])
      8'h40: begin
        n_cmd0++;
        if (n_cmd0 == 1) first_frame = f;
        cmd0_end  = neg_cnt;
        r[39:32]  = 8'h01;
        if (silent_cmd0) len = 0;
      end
      8'h48: begin
        n_cmd8++;
        f_cmd8 = f;
        r      = {cmd8_r1, 32'h0000_01AA};
        len    = 40;
      end
      8'h77: begin
        n_cmd55++;
        f_cmd55  = f;
        r[39:32] = 8'h01;
      end
      8'h69: begin
        n_acmd41++;
        f_acmd41 = f;
        r[39:32] = (n_acmd41 <= acmd41_busy) ? 8'h01 : 8'h00;
      end
      8'h7A: begin
        n_cmd58++;
        f_cmd58 = f;
        r       = 40'h00_C0FF_8000;
        len     = 40;
      end
      default: len = 0;
    endcase
    $display("frame cmd=%02h arg=%08h crc=%02h resp_bits=%0d resp=%010h",
             f[47:40], f[39:8], f[7:0], len, r);
    if (len > 0) begin
      for (int i = 0; i < 1 + (n_frames % 3); i++) resp_q.push_back(1'b1);
      for (int i = 0; i < len; i++) resp_q.push_back(r[39-i]);
    end
  endtask

  // Card receive side: shift MOSI on rising edges, frames start at the first 0 bit
  initial begin
    rx_cnt = 0;
    forever begin
      @(posedge SD_CK);
      if (bus.SD_CSn !== 1'b0) begin
        rx_cnt = 0;
      end else if (rx_cnt != 0 || bus.SD_MOSI === 1'b0) begin
        rx_sr = {rx_sr[46:0], bus.SD_MOSI};
        rx_cnt++;
        if (rx_cnt == 48) begin
          rx_cnt = 0;
          handle_frame(rx_sr);
        end
      end
    end
  end

  // Card transmit side: drive MISO on falling edges
  initial begin
    neg_cnt     = 0;
    bus.SD_MISO = 1'b1;
    forever begin
      @(negedge SD_CK);
      neg_cnt++;
      if (resp_q.size() > 0) bus.SD_MISO = resp_q.pop_front();
      else                   bus.SD_MISO = 1'b1;
    end
  end

  task automatic clear_card();
    resp_q.delete();
    n_cmd0 = 0; n_cmd8 = 0; n_cmd55 = 0; n_acmd41 = 0; n_cmd58 = 0; n_frames = 0;
    first_frame = '0; f_cmd8 = '0; f_cmd55 = '0; f_acmd41 = '0; f_cmd58 = '0;
  endtask

  task automatic do_reset();
    @(posedge SD_CK);
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge SD_CK);
    rst = 1'b0;
    clear_card();
  endtask

  task automatic wait_end(input string tag);
    int i;
    i = 0;
    while (!(init_o === 1'b1 || init_err === 1'b1) && i < 20000) begin
      @(posedge SD_CK);
      i++;
    end
    chk({tag, "_finished"}, init_o | init_err, 1'b1);
  endtask

  initial begin
    int pw;
    int i;

    // Reset values
    do_reset();
    @(posedge SD_CK);
    chk("rst_csn", bus.SD_CSn, 1'b1);
    chk("rst_mosi", bus.SD_MOSI, 1'b1);
    chk("rst_init", init_o, 1'b0);
    chk("rst_err", init_err, 1'b0);
    chk("rst_ccs", ccs, 1'b0);

    // Nominal card: ACMD41 busy twice, then ready
    cmd8_r1 = 8'h01; acmd41_busy = 2; silent_cmd0 = 1'b0;
    start = 1'b1;
    pw = 0; i = 0;
    while (bus.SD_CSn !== 1'b0 && i < 1000) begin
      @(posedge SD_CK);
      if (bus.SD_CSn === 1'b1 && bus.SD_MOSI === 1'b1) pw++;
      i++;
    end
    chk("pwrup_clks_ge_min", pw >= POWERUP, 1'b1);
    chk("cmd0_first_bit", bus.SD_MOSI, 1'b0);
    wait_end("nom");
    chk("nom_init", init_o, 1'b1);
    chk("nom_err", init_err, 1'b0);
    chk("nom_ccs", ccs, EXP_CCS);
    chk("nom_cmd0_frame", first_frame, 48'h40_0000_0000_95);
    chk("nom_cmd8_frame", f_cmd8, 48'h48_0000_01AA_87);
    chk("nom_cmd55_frame", f_cmd55, 48'h77_0000_0000_65);
    chk("nom_acmd41_frame", f_acmd41, 48'h69_4000_0000_77);
    chk("nom_n_cmd55", n_cmd55, 3);
    chk("nom_n_acmd41", n_acmd41, 3);
    chk("nom_n_cmd58", n_cmd58, EXP_N58);
`ifdef SD_INIT_CMD58_EN
    chk("nom_cmd58_frame", f_cmd58, 48'h7A_0000_0000_FD);
`endif
    repeat (20) @(posedge SD_CK);
    chk("done_hold_init", init_o, 1'b1);
    chk("done_csn", bus.SD_CSn, 1'b1);
    chk("done_no_rerun", n_cmd0, 1);

    // CMD8 answered 0x05 (v1 card): must fail before any CMD55
    do_reset();
    cmd8_r1 = 8'h05;
    start = 1'b1;
    wait_end("v1");
    chk("v1_err", init_err, 1'b1);
    chk("v1_init", init_o, 1'b0);
    @(posedge SD_CK);
    chk("v1_csn", bus.SD_CSn, 1'b1);
    chk("v1_n_cmd8", n_cmd8, 1);
    chk("v1_n_cmd55", n_cmd55, 0);

    // ACMD41 never ready: exactly RETRY pairs, then error
    do_reset();
    cmd8_r1 = 8'h01; acmd41_busy = 1000;
    start = 1'b1;
    wait_end("busy");
    chk("busy_err", init_err, 1'b1);
    chk("busy_init", init_o, 1'b0);
    chk("busy_n_cmd55", n_cmd55, RETRY);
    chk("busy_n_acmd41", n_acmd41, RETRY);

    // Silent card after CMD0: timeout latency from the last CMD0 bit
    do_reset();
    acmd41_busy = 2; silent_cmd0 = 1'b1;
    start = 1'b1;
    wait_end("silent");
    chk("silent_err", init_err, 1'b1);
    chk("silent_latency", neg_cnt - cmd0_end, TMO + 1);
    chk("silent_n_cmd8", n_cmd8, 0);

    // Reset during the CMD8 frame, then a full rerun
    do_reset();
    silent_cmd0 = 1'b0;
    start = 1'b1;
    i = 0;
    while (!(n_cmd0 == 1 && rx_cnt >= 20) && i < 5000) begin
      @(posedge SD_CK);
      i++;
    end
    chk("mid_in_cmd8", (n_cmd0 == 1 && rx_cnt >= 20 && bus.SD_CSn === 1'b0), 1'b1);
    rst = 1'b1;
    @(negedge SD_CK);
    @(posedge SD_CK);
    chk("mid_rst_csn", bus.SD_CSn, 1'b1);
    chk("mid_rst_mosi", bus.SD_MOSI, 1'b1);
    chk("mid_rst_init", init_o, 1'b0);
    chk("mid_rst_err", init_err, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    clear_card();
    @(posedge SD_CK);
    start = 1'b1;
    wait_end("rerun");
    chk("rerun_init", init_o, 1'b1);
    chk("rerun_err", init_err, 1'b0);
    chk("rerun_ccs", ccs, EXP_CCS);
    chk("rerun_n_cmd55", n_cmd55, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
